// File: rtl/config_frame_receiver.sv
// Configuration frame receiver.
// Collects a SYNC_BYTE-led frame of NUM_FIELDS little-endian 16-bit fields from a
// byte stream, applies it to cfg_out and announces it with a cfg_pulse strobe.
// Optional feature macro: CFG_CHECKSUM_EN adds a trailing XOR checksum byte.
module config_frame_receiver #(
  parameter int unsigned              NUM_FIELDS     = 4,
  parameter int unsigned              PULSE_CYCLES   = 33334,
  parameter int unsigned              TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]               SYNC_BYTE      = 8'hA5,
  parameter logic [NUM_FIELDS*16-1:0] DEFAULTS       = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_FIELDS*16-1:0] cfg_out,
  output logic                     cfg_pulse,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned CfgW      = NUM_FIELDS * 16;
  localparam int unsigned NumBytes  = 2 * NUM_FIELDS;
  localparam logic [3:0]  LastIdx   = 4'(NumBytes - 1);
  localparam logic [15:0] GapLast   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] PulseLast = 16'(PULSE_CYCLES - 1);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
`ifdef CFG_CHECKSUM_EN
  localparam logic [1:0] S_CHK  = 2'd2;
`endif
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CfgW-1:0] shadow_q, shadow_d;
  logic [CfgW-1:0] cfg_q, cfg_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     pcnt_q, pcnt_d;
  logic            pulse_q, pulse_d;
  logic            err_q, err_d;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
`endif

  // Next-state logic for the frame parser, gap timer and output strobe.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    gap_d    = gap_q;
    pcnt_d   = pcnt_q;
    pulse_d  = pulse_q;
    err_d    = 1'b0;
`ifdef CFG_CHECKSUM_EN
    xor_d    = xor_q;
`endif

    unique case (state_q)
      S_SYNC: begin
        // Non-sync bytes are line noise here and are dropped silently.
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_DATA;
          idx_d   = '0;
          gap_d   = '0;
`ifdef CFG_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end

      S_DATA: begin
        // A byte arriving on the timeout cycle still counts: rx_valid is tested first.
        if (rx_valid) begin
          for (int i = 0; i < NumBytes; i++) begin
            if (idx_q == 4'(i)) shadow_d[i*8 +: 8] = rx_data;
          end
          idx_d = idx_q + 4'd1;
          gap_d = '0;
`ifdef CFG_CHECKSUM_EN
          xor_d = xor_q ^ rx_data;
          if (idx_q == LastIdx) state_d = S_CHK;
`else
          if (idx_q == LastIdx) begin
            state_d = S_OUT;
            cfg_d   = shadow_d;
            pulse_d = 1'b1;
            pcnt_d  = '0;
          end
`endif
        end else if (gap_q == GapLast) begin
          state_d  = S_SYNC;
          err_d    = 1'b1;
          shadow_d = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end

`ifdef CFG_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          gap_d = '0;
          if (rx_data == xor_q) begin
            state_d = S_OUT;
            cfg_d   = shadow_q;
            pulse_d = 1'b1;
            pcnt_d  = '0;
          end else begin
            state_d  = S_SYNC;
            err_d    = 1'b1;
            shadow_d = '0;
          end
        end else if (gap_q == GapLast) begin
          state_d  = S_SYNC;
          err_d    = 1'b1;
          shadow_d = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
`endif

      S_OUT: begin
        // rx_valid is deliberately ignored while the strobe is active.
        if (pcnt_q == PulseLast) begin
          state_d = S_SYNC;
          pulse_d = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_SYNC;
        pulse_d = 1'b0;
      end
    endcase
  end

  // State registers; reset drops any frame in flight without flagging an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SYNC;
      idx_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= DEFAULTS;
      gap_q    <= '0;
      pcnt_q   <= '0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      gap_q    <= gap_d;
      pcnt_q   <= pcnt_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
`ifdef CFG_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign cfg_out   = cfg_q;
  assign cfg_pulse = pulse_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_SYNC);

endmodule

// File: tb/tb_config_frame_receiver.sv
// Self-checking bench for config_frame_receiver (NUM_FIELDS=2, PULSE_CYCLES=8,
// TIMEOUT_CYCLES=100). Expected configurations are queued as frames are sent and
// popped when cfg_pulse rises. Works with or without CFG_CHECKSUM_EN.
module tb_config_frame_receiver;

  localparam int unsigned NF  = 2;
  localparam int unsigned PC  = 8;
  localparam int unsigned TO  = 100;
  localparam logic [31:0] DEF = 32'h1234_ABCD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] cfg_out;
  logic        cfg_pulse;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int exp_err_pulses = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  config_frame_receiver #(
    .NUM_FIELDS    (NF),
    .PULSE_CYCLES  (PC),
    .TIMEOUT_CYCLES(TO),
    .SYNC_BYTE     (8'hA5),
    .DEFAULTS      (DEF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cfg_out  (cfg_out),
    .cfg_pulse(cfg_pulse),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // Scoreboard monitor: pops expected config on each strobe, checks strobe width
  // and that cfg_out moves only on a strobe's first cycle.
  logic        prev_pulse = 1'b0;
  logic [31:0] prev_cfg = DEF;
  int          width = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      width = 0;
    end else begin
      if (frame_err) err_pulses++;
      if (cfg_pulse && !prev_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cfg_out=%h, no frame was expected", cfg_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (cfg_out !== e) begin
            errors++;
            $display("FAIL scoreboard_cfg: got %h, expected %h", cfg_out, e);
          end
        end
        width = 1;
      end else if (cfg_pulse) begin
        width++;
      end else if (prev_pulse) begin
        checks++;
        if (width != PC) begin
          errors++;
          $display("FAIL pulse_width: got %0d cycles, expected %0d", width, PC);
        end
      end
      if (cfg_out !== prev_cfg && !(cfg_pulse && !prev_pulse)) begin
        errors++;
        $display("FAIL cfg_stable: cfg_out changed %h -> %h outside strobe entry",
                 prev_cfg, cfg_out);
      end
    end
    prev_pulse = cfg_pulse;
    prev_cfg   = cfg_out;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends a well-formed frame and checks cfg_out/cfg_pulse one cycle after the last byte.
  task automatic send_frame(input logic [31:0] cfg);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(cfg);
    send_byte(8'hA5);
    for (int i = 0; i < 2 * NF; i++) begin
      x ^= cfg[i*8 +: 8];
      send_byte(cfg[i*8 +: 8]);
    end
`ifdef CFG_CHECKSUM_EN
    send_byte(x);
`endif
    checks++;
    if (cfg_pulse !== 1'b1 || cfg_out !== cfg) begin
      errors++;
      $display("FAIL frame_latency: pulse=%b cfg_out=%h, expected pulse=1 cfg_out=%h",
               cfg_pulse, cfg_out, cfg);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cfg_out !== DEF || cfg_pulse !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cfg=%h pulse=%b err=%b busy=%b, expected %h 0 0 0",
               cfg_out, cfg_pulse, frame_err, busy, DEF);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_bad_checksum();
    logic [7:0] bytes [6];
    bytes = '{8'hA5, 8'h84, 8'h03, 8'h32, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    exp_err_pulses++;
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || cfg_out !== DEF || cfg_pulse !== 1'b0) begin
      errors++;
      $display("FAIL bad_checksum: err=%b busy=%b cfg=%h pulse=%b, expected 1 0 %h 0",
               frame_err, busy, cfg_out, cfg_pulse, DEF);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_checksum_pulse: frame_err=%b in second cycle, expected 0", frame_err);
    end
  endtask
`endif

  task automatic test_basic_frame();
    send_frame(32'h0032_0384);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_out: busy=%b, expected 1", busy);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h84);
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b busy=%b, expected 0 1", frame_err, busy);
    end
    @(negedge clk);
    exp_err_pulses++;
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: err=%b busy=%b, expected 1 0", frame_err, busy);
    end
    send_frame(32'hBEEF_0001);
    wait_idle();
  endtask

  // Second byte lands exactly on the cycle the gap timer would expire.
  task automatic test_byte_wins();
    logic [31:0] cfg;
    logic [7:0]  x;
    cfg = 32'h5A5A_1234;
    x   = 8'h00;
    exp_q.push_back(cfg);
    send_byte(8'hA5);
    repeat (TO - 2) @(negedge clk);
    for (int i = 0; i < 2 * NF; i++) begin
      x ^= cfg[i*8 +: 8];
      send_byte(cfg[i*8 +: 8]);
    end
`ifdef CFG_CHECKSUM_EN
    send_byte(x);
`endif
    checks++;
    if (cfg_pulse !== 1'b1 || cfg_out !== cfg) begin
      errors++;
      $display("FAIL byte_wins: pulse=%b cfg=%h, expected 1 %h", cfg_pulse, cfg_out, cfg);
    end
    wait_idle();
  endtask

  task automatic test_garbage_and_ignore();
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(32'h0032_0384);
    // A sync byte during the strobe must not open a new frame.
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_out !== 32'h0032_0384) begin
      errors++;
      $display("FAIL ignore_in_out: busy=%b cfg=%h, expected 0 00320384", busy, cfg_out);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5);
    send_byte(8'h84);
    send_byte(8'h03);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_out !== DEF || busy !== 1'b0 || frame_err !== 1'b0 || cfg_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: cfg=%h busy=%b err=%b pulse=%b, expected %h 0 0 0",
               cfg_out, busy, frame_err, cfg_pulse, DEF);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(32'hCAFE_F00D);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    send_frame(32'hA5A5_00A5);
    wait_idle();
    send_frame(32'hFFFF_0000);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef CFG_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_basic_frame();
    test_timeout();
    test_byte_wins();
    test_garbage_and_ignore();
    test_reset_midframe();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: %0d expected frames never applied, expected 0",
               exp_q.size());
    end
    checks++;
    if (err_pulses != exp_err_pulses) begin
      errors++;
      $display("FAIL frame_err_count: got %0d pulses, expected %0d", err_pulses, exp_err_pulses);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
